lbm_stage_sequencer: RTL

LBM_STAGE_SEQUENCER -- requirements
Module: lbm_stage_sequencer

---
 rtl/lbm_stage_sequencer_if.sv | 27 ++
 rtl/lbm_stage_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/lbm_stage_sequencer_if.sv
// lbm_stage_sequencer_if: control/status bundle between the stage sequencer and its driver.
interface lbm_stage_sequencer_if #(
    parameter int SEL_W  = 4,
    parameter int ITER_W = 16
);
    logic              start;
    logic [ITER_W-1:0] num_iter;
    logic [SEL_W-1:0]  last_sel;
    logic              stage_done;
    logic              abort;
    logic [SEL_W-1:0]  select;
    logic              stage_start;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [ITER_W-1:0] iter_cnt;

    modport master (
        output start, num_iter, last_sel, stage_done, abort,
        input  select, stage_start, busy, done, timeout_err, iter_cnt
    );

    modport slave (
        input  start, num_iter, last_sel, stage_done, abort,
        output select, stage_start, busy, done, timeout_err, iter_cnt
    );
endinterface

// File: rtl/lbm_stage_sequencer.sv
// lbm_stage_sequencer: steps the LBM datapath through stages 0..last_sel for num_iter sweeps,
// with a per-stage timeout and abort.
module lbm_stage_sequencer #(
    parameter int SEL_W   = 4,
    parameter int ITER_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input logic                  clk,
    input logic                  reset_n,
    lbm_stage_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(10);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FIN} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  select_q, select_d, last_sel_q, last_sel_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d, num_iter_q, num_iter_d, iter_inc;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              timeout_err_q, timeout_err_d, done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            select_q      <= '0;
            last_sel_q    <= '0;
            iter_cnt_q    <= '0;
            num_iter_q    <= '0;
            tcnt_q        <= '0;
            timeout_err_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            select_q      <= select_d;
            last_sel_q    <= last_sel_d;
            iter_cnt_q    <= iter_cnt_d;
            num_iter_q    <= num_iter_d;
            tcnt_q        <= tcnt_d;
            timeout_err_q <= timeout_err_d;
            // done lands the cycle after FIN, so an abort seen in FIN still cancels it
            done_q        <= state_q == FIN && !bus.abort;
        end
    end

    assign iter_inc = iter_cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        select_d      = select_q;
        last_sel_d    = last_sel_q;
        iter_cnt_d    = iter_cnt_q;
        num_iter_d    = num_iter_q;
        tcnt_d        = tcnt_q;
        timeout_err_d = timeout_err_q;
        if (state_q != IDLE && bus.abort) begin
            state_d  = IDLE;
            select_d = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    num_iter_d    = bus.num_iter;
                    last_sel_d    = bus.last_sel > MAX_SEL ? MAX_SEL : bus.last_sel;
                    iter_cnt_d    = '0;
                    timeout_err_d = 1'b0;
                    select_d      = '0;
                    state_d       = |bus.num_iter ? LAUNCH : FIN;
                end
                LAUNCH: begin
                    tcnt_d  = '0;
                    state_d = WAIT;
                end
                WAIT: if (bus.stage_done) begin
                    if (select_q < last_sel_q) begin
                        select_d = select_q + 1'b1;
                        state_d  = LAUNCH;
                    end else begin
                        iter_cnt_d = iter_inc;
                        select_d   = '0;
                        state_d    = iter_inc < num_iter_q ? LAUNCH : FIN;
                    end
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    select_d      = '0;
                    state_d       = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                default: begin
                    select_d = '0;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    assign bus.select      = select_q;
    assign bus.stage_start = state_q == LAUNCH && !bus.abort;
    assign bus.busy        = state_q != IDLE;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.iter_cnt    = iter_cnt_q;
endmodule
